// File: rtl/dac_spi_tx.sv
`default_nettype none
// ============================================================================
// Module   : dac_spi_tx
// Purpose  : Serialises x/y sample pairs into two 16-bit DAC frames
//            (channel A = x, channel B = y). Each frame is MSB first, with
//            cs_pin active-low, clk_pin idle-low and data_pin changing only
//            while clk_pin falls.
// Ports    : clk      - system clock, all state on the rising edge
//            reset    - asynchronous active-low reset
//            x, y     - 12-bit channel A / channel B samples
//            valid    - x/y pair offered this cycle
//            ready    - block idle, a pair is accepted when valid=1
//            cs_pin   - DAC chip select (active-low)
//            clk_pin  - DAC serial clock (idle low)
//            data_pin - DAC serial data
//            ldac_pin - DAC latch strobe, active-low (DAC_LDAC_EN only)
// Options  : define DAC_LDAC_EN to add ldac_pin and the LDAC_LO/LDAC_HI
//            states that latch both channels together after frame B.
// Revision : 1.0 - initial release
// ============================================================================
module dac_spi_tx #(
    parameter int unsigned CLK_DIV  = 2,     // clk cycles per dclk half-period
    parameter logic        GAIN_1X  = 1'b1,  // frame bit 13 (GA_n)
    parameter logic        VREF_BUF = 1'b0   // frame bit 14 (BUF)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] x,
    input  logic [11:0] y,
    input  logic        valid,
    output logic        ready,
    output logic        cs_pin,
    output logic        clk_pin,
`ifdef DAC_LDAC_EN
    output logic        ldac_pin,
`endif
    output logic        data_pin
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FRAME_A = 3'd1,
        GAP_A   = 3'd2,
        FRAME_B = 3'd3,
        GAP_B   = 3'd4
`ifdef DAC_LDAC_EN
        ,
        LDAC_LO = 3'd5,
        LDAC_HI = 3'd6
`endif
    } state_t;

    localparam logic [7:0] TICK_LAST = 8'(CLK_DIV - 1);
    localparam logic [5:0] HALF_LAST = 6'd32;

    state_t      state_q, state_d;
    logic [7:0]  tick_q, tick_d;
    logic [5:0]  half_q, half_d;
    logic [15:0] shift_q, shift_d;
    logic [11:0] y_q, y_d;
    logic        ready_q, ready_d;
    logic        cs_pin_q, cs_pin_d;
    logic        clk_pin_q, clk_pin_d;
    logic        data_pin_q, data_pin_d;
`ifdef DAC_LDAC_EN
    logic        ldac_pin_q, ldac_pin_d;
`endif
    logic        accept;
    logic        tick_end;
    logic        in_frame;

    function automatic logic [15:0] frame_word(input logic chan, input logic [11:0] sample);
        return {chan, VREF_BUF, GAIN_1X, 1'b1, sample};
    endfunction

    // Next-state, counters and shift register
    always_comb begin
        state_d  = state_q;
        tick_d   = tick_q;
        half_d   = half_q;
        shift_d  = shift_q;
        y_d      = y_q;
        accept   = valid && ready_q;
        tick_end = (tick_q == TICK_LAST);

        if (state_q == IDLE) begin
            tick_d = 8'd0;
            if (accept) begin
                state_d = FRAME_A;
                half_d  = 6'd0;
                shift_d = frame_word(1'b0, x);
                y_d     = y;
            end
        end else begin
            tick_d = tick_end ? 8'd0 : tick_q + 8'd1;
            if (tick_end) begin
                case (state_q)
                    FRAME_A, FRAME_B: begin
                        if (half_q == HALF_LAST) begin
                            half_d  = 6'd0;
                            state_d = (state_q == FRAME_A) ? GAP_A : GAP_B;
                        end else begin
                            half_d = half_q + 6'd1;
                            // Odd halves have clk_pin high; the next bit is
                            // presented as clk_pin falls.
                            if (half_q[0]) begin
                                shift_d = {shift_q[14:0], 1'b0};
                            end
                        end
                    end
                    GAP_A: begin
                        state_d = FRAME_B;
                        shift_d = frame_word(1'b1, y_q);
                    end
`ifdef DAC_LDAC_EN
                    GAP_B:   state_d = LDAC_LO;
                    LDAC_LO: state_d = LDAC_HI;
                    LDAC_HI: state_d = IDLE;
`else
                    GAP_B:   state_d = IDLE;
`endif
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    // Pins are registered from the current state, so they trail the state
    // register by one clk: cs_pin falls one cycle after the accept edge, and
    // ready returns one cycle after the state machine reaches IDLE.
    always_comb begin
        in_frame   = (state_q == FRAME_A) || (state_q == FRAME_B);
        ready_d    = (state_q == IDLE) && !accept;
        cs_pin_d   = !in_frame;
        clk_pin_d  = in_frame && half_q[0];
        data_pin_d = in_frame && shift_q[15];
`ifdef DAC_LDAC_EN
        ldac_pin_d = (state_q != LDAC_LO);
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            tick_q     <= 8'd0;
            half_q     <= 6'd0;
            shift_q    <= 16'd0;
            y_q        <= 12'd0;
            ready_q    <= 1'b1;
            cs_pin_q   <= 1'b1;
            clk_pin_q  <= 1'b0;
            data_pin_q <= 1'b0;
`ifdef DAC_LDAC_EN
            ldac_pin_q <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            tick_q     <= tick_d;
            half_q     <= half_d;
            shift_q    <= shift_d;
            y_q        <= y_d;
            ready_q    <= ready_d;
            cs_pin_q   <= cs_pin_d;
            clk_pin_q  <= clk_pin_d;
            data_pin_q <= data_pin_d;
`ifdef DAC_LDAC_EN
            ldac_pin_q <= ldac_pin_d;
`endif
        end
    end

    assign ready    = ready_q;
    assign cs_pin   = cs_pin_q;
    assign clk_pin  = clk_pin_q;
    assign data_pin = data_pin_q;
`ifdef DAC_LDAC_EN
    assign ldac_pin = ldac_pin_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dac_spi_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_dac_spi_tx
// Purpose  : Self-checking bench for dac_spi_tx. Instance 0 runs CLK_DIV=2,
//            instance 1 runs CLK_DIV=1; only one transmits at a time so a
//            single expected-frame queue serves both. A pin monitor rebuilds
//            each frame on clk_pin rises and pops the expected word when
//            cs_pin rises. Honours DAC_LDAC_EN for ldac_pin and latency.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dac_spi_tx;

`ifdef DAC_LDAC_EN
    localparam int HALVES = 70;
`else
    localparam int HALVES = 68;
`endif

    logic        clk;
    logic        rst_n;
    logic [11:0] x;
    logic [11:0] y;
    logic [1:0]  vld;
    logic [1:0]  rdy;
    logic [1:0]  cs;
    logic [1:0]  ck;
    logic [1:0]  dt;
`ifdef DAC_LDAC_EN
    logic [1:0]  ld;
`endif

    int n_checks = 0;
    int n_errors = 0;
    logic [15:0] exp_q[$];

    dac_spi_tx #(.CLK_DIV(2)) u_dut_div2 (
        .clk(clk), .reset(rst_n), .x(x), .y(y), .valid(vld[0]), .ready(rdy[0]),
        .cs_pin(cs[0]), .clk_pin(ck[0]),
`ifdef DAC_LDAC_EN
        .ldac_pin(ld[0]),
`endif
        .data_pin(dt[0])
    );

    dac_spi_tx #(.CLK_DIV(1)) u_dut_div1 (
        .clk(clk), .reset(rst_n), .x(x), .y(y), .valid(vld[1]), .ready(rdy[1]),
        .cs_pin(cs[1]), .clk_pin(ck[1]),
`ifdef DAC_LDAC_EN
        .ldac_pin(ld[1]),
`endif
        .data_pin(dt[1])
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] frame_word(input bit chan, input logic [11:0] s);
        return {chan, 1'b0, 1'b1, 1'b1, s};
    endfunction

    function automatic int div_of(input bit i);
        return i ? 1 : 2;
    endfunction

    // ---------------- pin monitor ----------------
    logic [15:0] m_word[2];
    int          m_rises[2];
    int          m_low[2];
    int          m_high[2];
    int          m_last_rise[2];
    bit          m_pcs[2];
    bit          m_pck[2];
    bit          m_pdt[2];
    bit          m_next_b[2];
    int          m_cyc = 0;
`ifdef DAC_LDAC_EN
    bit          m_pld[2];
    int          m_ldlow[2];
    int          m_fr[2];
    int          m_csr[2];
`endif

    task automatic mon_step(input bit i);
        logic [15:0] exp;
        if (!rst_n) begin
            m_word[i] = 16'd0; m_rises[i] = 0; m_low[i] = 0; m_high[i] = 0;
            m_last_rise[i] = 0; m_pcs[i] = 1'b1; m_pck[i] = 1'b0; m_pdt[i] = 1'b0;
            m_next_b[i] = 1'b0;
`ifdef DAC_LDAC_EN
            m_pld[i] = 1'b1; m_ldlow[i] = 0; m_fr[i] = 0; m_csr[i] = 0;
`endif
        end else begin
            if (!cs[i]) begin
                if (m_pcs[i]) begin
                    if (m_next_b[i]) check("cs_gap_len", m_high[i], div_of(i));
                    m_low[i] = 0; m_rises[i] = 0; m_word[i] = 16'd0;
                end
                m_low[i]++;
                if (ck[i] && !m_pck[i]) begin
                    check("data_stable_at_rise", dt[i], m_pdt[i]);
                    if (m_rises[i] > 0)
                        check("clk_pin_period", m_cyc - m_last_rise[i], 2 * div_of(i));
                    m_last_rise[i] = m_cyc;
                    m_word[i] = {m_word[i][14:0], dt[i]};
                    m_rises[i]++;
                end
            end else begin
                if (!m_pcs[i]) begin
                    check("rise_count", m_rises[i], 16);
                    check("frame_len", m_low[i], 33 * div_of(i));
                    if (exp_q.size() == 0) begin
                        check("frame_extra", 1, 0);
                    end else begin
                        exp = exp_q.pop_front();
                        check("frame_word", m_word[i], exp);
                    end
                    m_next_b[i] = !m_word[i][15];
                    m_high[i] = 0;
`ifdef DAC_LDAC_EN
                    m_fr[i]++;
                    m_csr[i] = m_cyc;
`endif
                end
                m_high[i]++;
                if (m_next_b[i]) begin
                    check("gap_clk_pin", ck[i], 1'b0);
                    check("gap_data_pin", dt[i], 1'b0);
                end
            end
`ifdef DAC_LDAC_EN
            if (!ld[i] && m_pld[i]) begin
                check("ldac_after_both_frames", m_fr[i], 2);
                check("ldac_delay", m_cyc - m_csr[i], div_of(i));
                m_fr[i] = 0; m_ldlow[i] = 0;
            end
            if (!ld[i]) m_ldlow[i]++;
            if (ld[i] && !m_pld[i]) check("ldac_low_len", m_ldlow[i], div_of(i));
            m_pld[i] = ld[i];
`endif
            m_pcs[i] = cs[i];
            m_pck[i] = ck[i];
            m_pdt[i] = dt[i];
        end
    endtask

    always @(negedge clk) begin
        mon_step(1'b0);
        mon_step(1'b1);
        m_cyc++;
    end

    // ---------------- stimulus ----------------
    task automatic start_txn(input bit inst, input logic [11:0] xv, input logic [11:0] yv,
                             input bit push);
        int n = 0;
        while (!rdy[inst] && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", rdy[inst], 1'b1);
        x = xv;
        y = yv;
        vld[inst] = 1'b1;
        if (push) begin
            exp_q.push_back(frame_word(1'b0, xv));
            exp_q.push_back(frame_word(1'b1, yv));
        end
    endtask

    task automatic tail(input bit inst, input bit hold, input logic [11:0] nx,
                        input logic [11:0] ny, input int pulse_at);
        int lat;
        @(posedge clk); #1;
        check("accept_cs_still_high", cs[inst], 1'b1);
        check("accept_ready_low", rdy[inst], 1'b0);
        if (hold) begin
            x = nx;
            y = ny;
            exp_q.push_back(frame_word(1'b0, nx));
            exp_q.push_back(frame_word(1'b1, ny));
        end else begin
            vld[inst] = 1'b0;
            x = ~x;
            y = ~y;
        end
        @(posedge clk); #1;
        check("cs_fall_after_accept", cs[inst], 1'b0);
        lat = 1;
        while (!rdy[inst] && lat < 400) begin
            if (!hold) begin
                vld[inst] = (pulse_at != 0) && (lat == pulse_at);
                if (vld[inst]) begin
                    x = 12'h555;
                    y = 12'h555;
                end
            end
            @(posedge clk); #1;
            lat++;
        end
        if (!hold) vld[inst] = 1'b0;
        check("ready_latency", lat, HALVES * div_of(inst) + 1);
    endtask

    initial begin
        clk   = 1'b0;
        rst_n = 1'b0;
        x     = 12'd0;
        y     = 12'd0;
        vld   = 2'b00;
        repeat (3) @(negedge clk);
        check("rst_ready0", rdy[0], 1'b1);
        check("rst_ready1", rdy[1], 1'b1);
        check("rst_cs", cs[0], 1'b1);
        check("rst_clk_pin", ck[0], 1'b0);
        check("rst_data_pin", dt[0], 1'b0);
`ifdef DAC_LDAC_EN
        check("rst_ldac", ld[0], 1'b1);
`endif
        rst_n = 1'b1;

        // Basic pair, first accept right after reset release
        start_txn(1'b0, 12'hABC, 12'h123, 1'b1);
        tail(1'b0, 1'b0, 12'h000, 12'h000, 0);

        // valid pulsed while busy must be ignored
        start_txn(1'b0, 12'h456, 12'h789, 1'b1);
        tail(1'b0, 1'b0, 12'h000, 12'h000, 40);

        // Back-to-back with valid held high
        start_txn(1'b0, 12'h5A5, 12'h0F0, 1'b1);
        tail(1'b0, 1'b1, 12'hC3C, 12'h00F, 0);
        tail(1'b0, 1'b0, 12'h000, 12'h000, 0);

        // Reset in the middle of frame A (half 10)
        start_txn(1'b0, 12'h321, 12'h654, 1'b0);
        @(posedge clk); #1;
        vld[0] = 1'b0;
        repeat (21) @(posedge clk);
        #3;
        check("abort_cs_low_before", cs[0], 1'b0);
        rst_n = 1'b0;
        #1;
        check("abort_cs", cs[0], 1'b1);
        check("abort_clk_pin", ck[0], 1'b0);
        check("abort_data_pin", dt[0], 1'b0);
        check("abort_ready", rdy[0], 1'b1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        start_txn(1'b0, 12'hDEF, 12'h9A8, 1'b1);
        tail(1'b0, 1'b0, 12'h000, 12'h000, 0);

        // CLK_DIV=1 extremes
        start_txn(1'b1, 12'hFFF, 12'h000, 1'b1);
        tail(1'b1, 1'b0, 12'h000, 12'h000, 0);

        repeat (20) @(negedge clk);
        check("frames_outstanding", exp_q.size(), 0);
        check("idle_cs0", cs[0], 1'b1);
        check("idle_cs1", cs[1], 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dac_spi_tx.md
DAC_SPI_TX -- requirements
Module: dac_spi_tx

Interface
- REQ-001: Parameter CLK_DIV, default 2, clk cycles per dclk half-period; legal range 1..255.
- REQ-002: Parameter GAIN_1X, default 1, value driven on frame bit 13 (GA_n).
- REQ-003: Parameter VREF_BUF, default 0, value driven on frame bit 14 (BUF).
- REQ-004: clk  input  1  single system clock; all state on rising edge.
- REQ-005: reset  input  1  asynchronous, active-low reset.
- REQ-006: x  input  12  channel A sample (horizontal deflection).
- REQ-007: y  input  12  channel B sample (vertical deflection).
- REQ-008: valid  input  1  x/y pair offered this cycle.
- REQ-009: ready  output  1  block idle, will accept a pair this cycle.
- REQ-010: cs_pin  output  1  DAC chip select, active-low.
- REQ-011: clk_pin  output  1  DAC serial clock, idle low.
- REQ-012: data_pin  output  1  DAC serial data, MSB first.

Function
- REQ-013: Transfer occurs on a rising clk edge with valid=1 and ready=1; x and y are registered on that edge, later changes ignored.
- REQ-014: ready=1 only in state IDLE; valid while ready=0 is ignored, never queued.
- REQ-015: States: IDLE -> FRAME_A -> GAP_A -> FRAME_B -> GAP_B -> (LDAC_LO -> LDAC_HI, macro only) -> IDLE; no other transitions.
- REQ-016: A half-period tick counter counts CLK_DIV clk cycles; all pin changes occur only on tick boundaries, counter cleared on accept.
- REQ-017: Frame word: bit15 channel (0=A/x, 1=B/y), bit14 VREF_BUF, bit13 GAIN_1X, bit12 SHDN_n=1, bits11:0 sample.
- REQ-018: Frame = 33 half-periods with cs_pin=0: half 0 clk_pin=0 with bit15 on data_pin; halves 1..32 alternate clk_pin high/low; data_pin advances to next bit when clk_pin falls; exactly 16 rising clk_pin edges per frame.
- REQ-019: cs_pin falls on the clk edge immediately after accept; data_pin stable across every clk_pin rising edge.
- REQ-020: After half 32 cs_pin=1 for exactly one half-period (GAP state), clk_pin=0, data_pin=0.
- REQ-021: Without macro, ready reasserts exactly 68*CLK_DIV+1 clk cycles after the accept edge (137 at CLK_DIV=2).
- REQ-022: Back-to-back: valid held high accepts the next pair on the first cycle ready=1; no extra idle cycles.
- REQ-023: x=0xFFF and x=0x000 are sent unmodified; no saturation or sign handling.

Reset
- REQ-024: While reset=0: state IDLE, cs_pin=1, clk_pin=0, data_pin=0, ready=1, tick counter and shift register 0; valid ignored.
- REQ-025: Reset asserted mid-frame aborts immediately (asynchronously); cs_pin rises without completing the frame; no partial frame resumes after release.
- REQ-026: First accept possible on the first rising clk edge after reset release.

Configuration
- REQ-027: Macro DAC_LDAC_EN adds output ldac_pin (1 bit, active-low latch, reset value 1).
- REQ-028: With DAC_LDAC_EN: after GAP_B, ldac_pin=0 for one half-period (LDAC_LO) then 1 for one half-period (LDAC_HI) before IDLE; ready latency becomes 70*CLK_DIV+1.
- REQ-029: Without DAC_LDAC_EN: no ldac_pin port, no LDAC states; each channel latches on its own cs_pin rise.

Verification
- REQ-030: CLK_DIV=2, accept x=0xABC,y=0x123 -> frames 0x3ABC then 0xB123 sampled on clk_pin rise (GAIN_1X=1, VREF_BUF=0), 16 rises each, ready back after 137 cycles.
- REQ-031: valid held high with two pairs -> second cs_pin fall exactly 2 cycles after ready rise-cycle accept; no frames dropped or duplicated.
- REQ-032: Pulse valid while ready=0 with x=0x555 -> no extra frame, in-flight frame data unchanged.
- REQ-033: Assert reset at half 10 of FRAME_A -> cs_pin=1, clk_pin=0, ready=1 within same cycle; next accept produces full correct frames.
- REQ-034: CLK_DIV=1, x=0xFFF,y=0x000 -> frames 0x3FFF/0xB000, clk_pin period 2 clk cycles, ready after 69 cycles.
- REQ-035: DAC_LDAC_EN defined, CLK_DIV=2 -> ldac_pin low 2 cycles after GAP_B, only after both frames, ready after 141 cycles.
